// File: rtl/decode_writeback_if.sv
// Decode/write-back bus: operand decode request, write-back data, operands and debug port.
`default_nettype none

interface decode_writeback_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        halted;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    modport master (
        output icode, ifun, rA, rB, cnd, valE, valM, dbg_sel,
        input  valA, valB, halted, dbg_val
    );

    modport slave (
        input  icode, ifun, rA, rB, cnd, valE, valM, dbg_sel,
        output valA, valB, halted, dbg_val
    );
endinterface

`default_nettype wire

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 register file with combinational decode/read and edge-triggered write-back.
// Revision: 1.0
`default_nettype none

module decode_writeback #(
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'h4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    decode_writeback_if.slave bus
);

    localparam logic [3:0] C_NONE = 4'hF;

    logic [63:0] regs_q [NREG];
    logic        halted_q;
    logic        halted_d;

    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic        w_halt_insn;
    logic        w_wr_en;
    logic        w_unused_ifun;

    function automatic logic [63:0] rd(input logic [3:0] id);
        rd = (id == C_NONE) ? 64'd0 : regs_q[id];
    endfunction

    always_comb begin
        w_src_a = C_NONE;
        w_src_b = C_NONE;
        w_dst_e = C_NONE;
        w_dst_m = C_NONE;
        case (bus.icode)
            4'h2: begin
                w_src_a = bus.rA;
                if (bus.cnd) w_dst_e = bus.rB;
            end
            4'h3: w_dst_e = bus.rB;
            4'h4: begin
                w_src_a = bus.rA;
                w_src_b = bus.rB;
            end
            4'h5: begin
                w_src_b = bus.rB;
                w_dst_m = bus.rA;
            end
            4'h6: begin
                w_src_a = bus.rA;
                w_src_b = bus.rB;
                w_dst_e = bus.rB;
            end
            4'h8: begin
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'h9: begin
                w_src_a = RSP_ID;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'hA: begin
                w_src_a = bus.rA;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'hB: begin
                w_src_a = RSP_ID;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
                w_dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    assign w_halt_insn   = (bus.icode == 4'h0) || (bus.icode > 4'hB);
    assign w_wr_en       = !halted_q && !w_halt_insn;
    assign halted_d      = halted_q || w_halt_insn;
    assign w_unused_ifun = ^bus.ifun;

    // Reads see pre-edge state only; a same-cycle write is never forwarded.
    assign bus.valA    = rd(w_src_a);
    assign bus.valB    = rd(w_src_b);
    assign bus.dbg_val = rd(bus.dbg_sel);
    assign bus.halted  = halted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 64'd0;
            end
            halted_q <= 1'b0;
        end else begin
            // valM write comes second so it wins when dstE == dstM.
            if (w_wr_en) begin
                if (w_dst_e != C_NONE) regs_q[w_dst_e] <= bus.valE;
                if (w_dst_m != C_NONE) regs_q[w_dst_m] <= bus.valM;
            end
            halted_q <= halted_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: directed scenarios then randomized traffic vs a behavioural model.
`default_nettype none

module tb_decode_writeback;

    logic clk;
    logic reset;

    decode_writeback_if bus ();

    decode_writeback #(.NREG(15), .RSP_ID(4'h4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic        h;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_reg [15];
    bit          m_halted;
    bit          m_known;
    int          n_vec;
    int          n_err;

    function automatic logic [63:0] m_rd(input logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return m_reg[id];
    endfunction

    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 4'h5 || ic == 4'hB) return ra;
        return 4'hF;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One instruction cycle: drive just after an edge, record the expected outputs, then advance the model across the next edge.
    task automatic step(input logic rst, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm, input logic [3:0] ds);
        exp_t e;
        logic [3:0] de;
        logic [3:0] dm;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.icode   = ic;
        bus.ifun    = 4'($urandom);
        bus.rA      = ra;
        bus.rB      = rb;
        bus.cnd     = c;
        bus.valE    = ve;
        bus.valM    = vm;
        bus.dbg_sel = ds;
        e.chk = m_known;
        e.a   = m_rd(m_src_a(ic, ra));
        e.b   = m_rd(m_src_b(ic, rb));
        e.d   = m_rd(ds);
        e.h   = m_halted;
        sb.push_back(e);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 64'd0;
            m_halted = 1'b0;
            m_known  = 1'b1;
        end else if (!m_halted) begin
            if (ic == 4'h0 || ic > 4'hB) begin
                m_halted = 1'b1;
            end else begin
                de = m_dst_e(ic, rb, c);
                dm = m_dst_m(ic, ra);
                if (de != 4'hF) m_reg[de] = ve;
                if (dm != 4'hF) m_reg[dm] = vm;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("valA",    bus.valA,           e.a);
                    check("valB",    bus.valB,           e.b);
                    check("dbg_val", bus.dbg_val,        e.d);
                    check("halted",  {63'd0, bus.halted}, {63'd0, e.h});
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0]  ic;
        logic [63:0] ve;
        logic [63:0] vm;
        n_vec    = 0;
        n_err    = 0;
        m_known  = 1'b0;
        m_halted = 1'b0;
        reset       = 1'b1;
        bus.icode   = 4'h1;
        bus.ifun    = 4'h0;
        bus.rA      = 4'hF;
        bus.rB      = 4'hF;
        bus.cnd     = 1'b0;
        bus.valE    = 64'd0;
        bus.valM    = 64'd0;
        bus.dbg_sel = 4'h0;

        step(1, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h0);
        // reset clears an earlier write and wins over a concurrent one
        step(0, 4'h3, 4'hF, 4'h3, 0, 64'h55,   64'd0,     4'h3);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h3);
        step(1, 4'h3, 4'hF, 4'h3, 0, 64'h66,   64'd0,     4'h3);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h3);
        // OPq
        step(0, 4'h3, 4'hF, 4'h1, 0, 64'd30,   64'd0,     4'h1);
        step(0, 4'h3, 4'hF, 4'h2, 0, 64'd50,   64'd0,     4'h2);
        step(0, 4'h6, 4'h1, 4'h2, 0, 64'd80,   64'd0,     4'h2);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h2);
        // cmov gating
        step(0, 4'h2, 4'h1, 4'h5, 0, 64'd30,   64'd0,     4'h1);
        step(0, 4'h2, 4'h1, 4'h5, 1, 64'd30,   64'd0,     4'h5);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h5);
        // push / pop / pop %rsp
        step(0, 4'h3, 4'hF, 4'h4, 0, 64'd100,  64'd0,     4'h4);
        step(0, 4'hA, 4'h1, 4'hF, 0, 64'd92,   64'd0,     4'h4);
        step(0, 4'hB, 4'h3, 4'hF, 0, 64'd100,  64'h77,    4'h4);
        step(0, 4'hB, 4'h4, 4'hF, 0, 64'd108,  64'h200,   4'h3);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h4);
        // halt, then invalid icode after reset
        step(0, 4'h0, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);
        step(0, 4'h3, 4'hF, 4'h6, 0, 64'd9,    64'd0,     4'h6);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);
        step(1, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);
        step(0, 4'hC, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);
        step(0, 4'h3, 4'hF, 4'h6, 0, 64'd9,    64'd0,     4'h6);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'hF);
        step(1, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);
        step(0, 4'h1, 4'hF, 4'hF, 0, 64'd0,    64'd0,     4'h6);

        for (int n = 0; n < 600; n++) begin
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 11));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            step(($urandom_range(0, 29) == 0), ic, 4'($urandom), 4'($urandom),
                 1'($urandom), ve, vm, 4'($urandom));
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
